// File: rtl/board_io_pkg.sv
// ---------------------------------------------------------------------------
// board_io_pkg : bus field layout shared by board_io and its debouncers. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package board_io_pkg;

  localparam int SW_LSB     = 0;
  localparam int SW_W       = 10;
  localparam int KEY_LSB    = 10;
  localparam int KEY_W      = 4;
  localparam int LED_LSB    = 0;
  localparam int LED_W      = 10;
  localparam int HEX_LSB    = 10;
  localparam int HEX_DIGITS = 6;
  localparam int SEG_W      = 7;

  // 10 ms at 50 MHz
  localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

endpackage

`default_nettype wire

// File: rtl/board_io_debouncer.sv
// ---------------------------------------------------------------------------
// debouncer : 2-flop synchroniser plus persistence counter for one pin. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module debouncer
  import board_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level
);

  localparam int            CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic [CW-1:0] count;
  logic          sample;

  // Counter logic only ever sees the active-high "asserted" form.
  assign sample = sync2 ^ ACTIVE_LOW;
  assign level  = stable;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1  <= ACTIVE_LOW;
      sync2  <= ACTIVE_LOW;
      stable <= 1'b0;
      count  <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sample == stable) begin
        count <= '0;
      end else if (count == LAST) begin
        stable <= sample;
        count  <= '0;
      end else begin
        count <= count + CW'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/board_io.sv
// ---------------------------------------------------------------------------
// board_io : debounced switch/key input bus and registered LED/7-seg outputs. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module board_io
  import board_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
  parameter int IO_INPUT_BUS_LEN  = 14,
  parameter int IO_OUTPUT_BUS_LEN = 52
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [SW_W-1:0]              sw,
  input  logic [KEY_W-1:0]             key_n,
  output logic [IO_INPUT_BUS_LEN-1:0]  io_input_bus,
  input  logic [IO_OUTPUT_BUS_LEN-1:0] io_output_bus,
  output logic [LED_W-1:0]             ledr,
  output logic [HEX_DIGITS*SEG_W-1:0]  hex_n
);

  logic [IO_INPUT_BUS_LEN-1:0] pins;

  assign pins = {key_n, sw};

  for (genvar i = 0; i < IO_INPUT_BUS_LEN; i++) begin : g_chan
    debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (i >= KEY_LSB)
    ) u_debouncer (
      .clock (clock),
      .reset (reset),
      .raw   (pins[i]),
      .level (io_input_bus[i])
    );
  end

  // Segment patterns pass through raw; only the pin polarity is flipped.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ledr  <= '0;
      hex_n <= '1;
    end else begin
      ledr  <= io_output_bus[LED_LSB +: LED_W];
      hex_n <= ~io_output_bus[HEX_LSB +: HEX_DIGITS*SEG_W];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_board_io.sv
// ---------------------------------------------------------------------------
// tb_board_io : directed plus random stimulus against a sliding-window reference. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_board_io;

  localparam int D = 4;

  logic        clock;
  logic        reset;
  logic [9:0]  sw;
  logic [3:0]  key_n;
  logic [13:0] io_input_bus;
  logic [51:0] io_output_bus;
  logic [9:0]  ledr;
  logic [41:0] hex_n;

  int n_pass   = 0;
  int n_checks = 0;

  board_io #(
    .DEBOUNCE_CYCLES   (D),
    .IO_INPUT_BUS_LEN  (14),
    .IO_OUTPUT_BUS_LEN (52)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .sw            (sw),
    .key_n         (key_n),
    .io_input_bus  (io_input_bus),
    .io_output_bus (io_output_bus),
    .ledr          (ledr),
    .hex_n         (hex_n)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: a bit flips once the last D synced samples all disagree with it.
  // hist holds asserted-form pin captures, newest at the back; the
  // synchroniser means the newest capture is not yet visible to the filter.
  logic [13:0] hist[$];
  logic [13:0] m_bus;
  logic [13:0] m_next;
  logic [9:0]  m_led;
  logic [41:0] m_hex;
  bit          all_diff;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      hist = {};
      for (int i = 0; i <= D; i++) hist.push_back(14'h0);
      m_bus = '0;
      m_led = '0;
      m_hex = '1;
    end else begin
      m_next = m_bus;
      for (int b = 0; b < 14; b++) begin
        all_diff = 1'b1;
        for (int j = 1; j <= D; j++)
          if (hist[hist.size()-1-j][b] == m_bus[b]) all_diff = 1'b0;
        if (all_diff) m_next[b] = ~m_bus[b];
      end
      m_bus = m_next;
      m_led = io_output_bus[9:0];
      m_hex = ~io_output_bus[51:10];
      hist.push_back({~key_n, sw});
      void'(hist.pop_front());
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_model();
    check("bus_vs_model", 64'(io_input_bus), 64'(m_bus));
    check("ledr_vs_model", 64'(ledr), 64'(m_led));
    check("hex_vs_model", 64'(hex_n), 64'(m_hex));
  endtask

  task automatic edges(input int n);
    repeat (n) begin
      @(negedge clock);
      check_model();
    end
  endtask

  initial begin
    sw            = 10'h3FF;
    key_n         = 4'h0;
    io_output_bus = 52'hF_FFFF_FFFF_FFFF;
    reset         = 1'b1;
    #1 reset      = 1'b0;

    // Reset dominates, before and across clock edges
    #3;
    check("rst_bus_async", 64'(io_input_bus), 64'h0);
    check("rst_ledr_async", 64'(ledr), 64'h0);
    check("rst_hex_async", 64'(hex_n), 64'h3FF_FFFF_FFFF);
    edges(3);
    check("rst_bus_held", 64'(io_input_bus), 64'h0);
    check("rst_hex_held", 64'(hex_n), 64'h3FF_FFFF_FFFF);

    sw            = '0;
    key_n         = 4'hF;
    io_output_bus = '0;
    reset         = 1'b1;
    edges(8);

    // Clean switch edge: visible after edge k+5, not k+4
    sw[3] = 1'b1;
    edges(5);
    check("sw3_rise_early", 64'(io_input_bus[3]), 64'h0);
    edges(1);
    check("sw3_rise", 64'(io_input_bus[3]), 64'h1);
    sw[3] = 1'b0;
    edges(5);
    check("sw3_fall_early", 64'(io_input_bus[3]), 64'h1);
    edges(1);
    check("sw3_fall", 64'(io_input_bus[3]), 64'h0);

    // Three-cycle press is rejected, four-cycle press accepted
    key_n[2] = 1'b0;
    edges(3);
    key_n[2] = 1'b1;
    edges(10);
    check("key2_glitch", 64'(io_input_bus[12]), 64'h0);
    key_n[2] = 1'b0;
    edges(5);
    check("key2_press_early", 64'(io_input_bus[12]), 64'h0);
    edges(1);
    check("key2_press", 64'(io_input_bus[12]), 64'h1);
    key_n[2] = 1'b1;
    edges(8);
    check("key2_release", 64'(io_input_bus[12]), 64'h0);

    // Bouncing button then held
    for (int i = 0; i < 10; i++) begin
      key_n[0] = ~key_n[0];
      edges(1);
      check("key0_bounce", 64'(io_input_bus[10]), 64'h0);
    end
    key_n[0] = 1'b0;
    edges(5);
    check("key0_held_early", 64'(io_input_bus[10]), 64'h0);
    edges(1);
    check("key0_held", 64'(io_input_bus[10]), 64'h1);
    key_n[0] = 1'b1;
    edges(8);

    // Output map
    io_output_bus = {42'h0, 10'h2A5};
    edges(1);
    check("ledr_map", 64'(ledr), 64'h2A5);
    check("hex_blank", 64'(hex_n), 64'h3FF_FFFF_FFFF);
    io_output_bus[16:10] = 7'h3F;
    edges(1);
    check("hex0_map", 64'(hex_n[6:0]), 64'h40);
    check("hex1_5_blank", 64'(hex_n[41:7]), 64'h7_FFFF_FFFF);
    check("ledr_hold", 64'(ledr), 64'h2A5);

    // Reset mid-count discards progress
    sw[0] = 1'b1;
    edges(4);
    reset = 1'b0;
    #1;
    check("midrst_bus", 64'(io_input_bus), 64'h0);
    check("midrst_ledr", 64'(ledr), 64'h0);
    check("midrst_hex", 64'(hex_n), 64'h3FF_FFFF_FFFF);
    edges(2);
    reset = 1'b1;
    edges(5);
    check("midrst_sw0_early", 64'(io_input_bus[0]), 64'h0);
    edges(1);
    check("midrst_sw0", 64'(io_input_bus[0]), 64'h1);

    // Random phase: sparse toggles, occasional bursts, rare resets
    for (int c = 0; c < 600; c++) begin
      int idx;
      if ($urandom_range(0, 5) == 0) begin
        idx = $urandom_range(0, 13);
        if (idx < 10) sw[idx] = ~sw[idx];
        else key_n[idx-10] = ~key_n[idx-10];
      end
      if ($urandom_range(0, 3) == 0)
        io_output_bus = 52'({$urandom(), $urandom()});
      if ($urandom_range(0, 150) == 0) begin
        reset = 1'b0;
        #1;
        check("rand_rst_bus", 64'(io_input_bus), 64'h0);
        edges(1);
        reset = 1'b1;
      end
      edges(1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/board_io.md
# board_io

Board-side endpoint of the core's memory-mapped IO buses. Synchronises and debounces the 10 slide switches and 4 push-buttons into the 14-bit `io_input_bus` the core reads. Registers the core's 52-bit `io_output_bus` onto 10 LEDs and six active-low 7-segment displays. Sits at top level between the FPGA pins and `core`.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 500000, consecutive cycles a new level must persist before it is accepted (10 ms at 50 MHz); legal range ≥1.
- `IO_INPUT_BUS_LEN`, 14, width of `io_input_bus`; fixed.
- `IO_OUTPUT_BUS_LEN`, 52, width of `io_output_bus`; fixed.

Ports:
- `clock`  in  1  single system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `sw`  in  10  raw slide switches, active-high, asynchronous to `clock`.
- `key_n`  in  4  raw push-buttons, active-low (0 = pressed), asynchronous.
- `io_input_bus`  out  14  to core: [9:0] debounced `sw`, [13:10] debounced key pressed (active-high).
- `io_output_bus`  in  52  from core: [9:0] LEDs; [51:10] HEX0..HEX5, 7 bits each, HEX*n* at [16+7n:10+7n], bit0 = segment a … bit6 = segment g, 1 = lit.
- `ledr`  out  10  LED pins, active-high.
- `hex_n`  out  42  segment pins, same packing as bus, active-low (0 = lit).

## Operation
- Input path, per bit (14 independent channels): 2-flop synchroniser → debouncer.
- Key channels invert after synchronisation; every debouncer works on active-high "asserted" levels.
- Debouncer state: `stable` (drives bus bit), `count` (width clog2(DEBOUNCE_CYCLES+1)).
  - Synced sample == `stable`: `count` ← 0.
  - Sample != `stable` and `count` < DEBOUNCE_CYCLES−1: `count` increments.
  - Sample != `stable` and `count` == DEBOUNCE_CYCLES−1: `stable` ← sample, `count` ← 0.
  - Any glitch back to `stable` before acceptance restarts the count from 0.
- Output path: `ledr` ← `io_output_bus[9:0]`, `hex_n` ← ~`io_output_bus[51:10]`, both registered. No decoding; the core writes raw segment patterns.
- Reset (asynchronous, while `reset` = 0):
  - Synchroniser flops go to the released level: `sw` stages 0, `key_n` stages 1.
  - `stable` and `count` go to 0, so `io_input_bus` = 0.
  - `ledr` = 0 and `hex_n` = all 1s (blank).
- Reset mid-count discards progress. After release, a held input needs the full latency again.

## Timing
- Input latency: pin level change set up before edge k. sync1 captures at k, sync2 at k+1, `stable` updates at edge k+1+DEBOUNCE_CYCLES (DEBOUNCE_CYCLES+2 edges total).
- Input pulses shorter than DEBOUNCE_CYCLES synced cycles never reach `io_input_bus`.
- Output latency: exactly 1 edge from `io_output_bus` to pins.
- All 14 channels are independent. Simultaneous changes on several bits each obey their own latency; no ordering between bits.
- DEBOUNCE_CYCLES = 1: a new synced level is accepted on the first cycle it differs.

## Structure
- Package `board_io_pkg`:
  - field offsets/widths: SW_LSB=0, SW_W=10, KEY_LSB=10, KEY_W=4, LED_LSB=0, LED_W=10, HEX_LSB=10, HEX_DIGITS=6, SEG_W=7;
  - default DEBOUNCE_CYCLES.
- Sub-module `debouncer`: synchroniser plus counter, parameter DEBOUNCE_CYCLES, ports `clock`, `reset`, `raw`, `level`. Instantiated 14× in a generate loop. Output registers stay inline in `board_io`.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4.
- Reset: hold `reset` = 0, `sw` = 10'h3FF, `key_n` = 4'h0 → `io_input_bus` = 0, `ledr` = 0, `hex_n` = all 1s, even mid-cycle, asynchronously.
- Clean switch: after reset, `sw[3]` 0→1 before edge k → `io_input_bus[3]` = 1 first after edge k+5, not before. Release → returns to 0 after the same latency.
- Glitch rejection:
  - `key_n[2]` low for 3 cycles then high → `io_input_bus[12]` stays 0.
  - Low for 4 consecutive synced cycles → `io_input_bus[12]` = 1.
- Bouncing button: `key_n[0]` toggles every cycle for 10 cycles, then held low → bit 10 rises exactly 6 edges after the final transition.
- Output map: `io_output_bus` = {42'h0, 10'h2A5}, then HEX0 field = 7'h3F → `ledr` = 10'h2A5 and `hex_n[6:0]` = 7'h40, one edge after each write. Other digits stay 7'h7F.
- Reset mid-count: `sw[0]` high, assert `reset` after 2 counting cycles, release → bit 0 rises the full 6 edges after release, never earlier.
